fwd_hazard_scoreboard: RTL and testbench

- Parametrised successor to the EX-stage forwarding logic. It tracks in-flight writers in an internal scoreboard shift register instead of taking MEM/WB register fields as inputs.
- Produces per-operand forwarding selects for the EX-stage instruction.
- Produces a load-use stall for the ID-stage instruction.
- Supports N source operands, arbitrary forwarding depth and multi-cycle load latency. Register 0 is never forwarded.

---
 rtl/fwd_hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: EX forwarding selects and ID load-use stall driven by an in-flight writer scoreboard.
// Optional counters o_stall_cnt/o_fwd_cnt exist only when FWD_PERF_CNT_EN is defined.
module fwd_hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int N_SRC     = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_advance,
  input  logic [REG_AW-1:0]       i_ex_dst,
  input  logic                    i_ex_wr_en,
  input  logic                    i_ex_is_load,
  input  logic [N_SRC*REG_AW-1:0] i_ex_src,
  input  logic [N_SRC-1:0]        i_ex_src_used,
  input  logic [N_SRC*REG_AW-1:0] i_id_src,
  input  logic [N_SRC-1:0]        i_id_src_used,
  output logic [N_SRC*SEL_W-1:0]  o_fwd_sel,
  output logic                    o_stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]             o_stall_cnt,
  output logic [31:0]             o_fwd_cnt
`endif
);
  logic [FWD_DEPTH:1] valid_q, valid_d, ld_q, ld_d;
  logic [REG_AW-1:0]  dst_q [1:FWD_DEPTH];
  logic [REG_AW-1:0]  dst_d [1:FWD_DEPTH];
  logic [REG_AW-1:0]  ex_r, id_r;
  logic [SEL_W-1:0]   sel;
  logic               st;
  always_comb begin
    valid_d = valid_q;
    ld_d    = ld_q;
    dst_d   = dst_q;
    if (i_advance) begin
      for (int s = FWD_DEPTH; s >= 2; s--) begin
        valid_d[s] = valid_q[s-1];
        ld_d[s]    = ld_q[s-1];
        dst_d[s]   = dst_q[s-1];
      end
      valid_d[1] = i_ex_wr_en;
      ld_d[1]    = i_ex_is_load;
      dst_d[1]   = i_ex_dst;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      ld_q    <= '0;
      for (int s = 1; s <= FWD_DEPTH; s++) dst_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      ld_q    <= ld_d;
      dst_q   <= dst_d;
    end
  end
  // Scan oldest to youngest so the youngest matching writer decides.
  always_comb begin
    o_fwd_sel = '0;
    o_stall   = 1'b0;
    ex_r      = '0;
    id_r      = '0;
    sel       = '0;
    st        = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      ex_r = i_ex_src[k*REG_AW +: REG_AW];
      id_r = i_id_src[k*REG_AW +: REG_AW];
      sel  = '0;
      st   = 1'b0;
      for (int s = FWD_DEPTH; s >= 1; s--) begin
        if (valid_q[s] && dst_q[s] == ex_r)
          sel = (ld_q[s] && s <= LOAD_LAT) ? '0 : SEL_W'(s);
        if (valid_q[s] && dst_q[s] == id_r)
          st = ld_q[s] && (s + 1 <= LOAD_LAT);
      end
      if (i_ex_wr_en && i_ex_dst == id_r)
        st = i_ex_is_load && (LOAD_LAT >= 1);
      o_fwd_sel[k*SEL_W +: SEL_W] = (i_ex_src_used[k] && ex_r != '0) ? sel : '0;
      if (i_id_src_used[k] && id_r != '0 && st) o_stall = 1'b1;
    end
  end
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + ((i_advance && o_stall && stall_cnt_q != '1) ? 32'd1 : 32'd0);
    fwd_cnt_d   = fwd_cnt_q + ((i_advance && |o_fwd_sel && fwd_cnt_q != '1) ? 32'd1 : 32'd0);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end
  assign o_stall_cnt = stall_cnt_q;
  assign o_fwd_cnt   = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed checks of forwarding selects and load-use stall.
// A second instance uses FWD_DEPTH=3, LOAD_LAT=2; counters are checked when FWD_PERF_CNT_EN is defined.
module tb_fwd_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst, adv, ex_wr, ex_ld;
  logic [4:0] ex_dst;
  logic [9:0] ex_src, id_src;
  logic [1:0] ex_used, id_used;
  logic [3:0] sel_a, sel_b;
  logic       stall_a, stall_b;
  int         errors = 0;
  int         checks = 0;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif
  always #5 clk = ~clk;
  fwd_hazard_scoreboard dut_a (
    .i_clk(clk), .i_rst(rst), .i_advance(adv), .i_ex_dst(ex_dst), .i_ex_wr_en(ex_wr),
    .i_ex_is_load(ex_ld), .i_ex_src(ex_src), .i_ex_src_used(ex_used), .i_id_src(id_src),
    .i_id_src_used(id_used), .o_fwd_sel(sel_a), .o_stall(stall_a)
`ifdef FWD_PERF_CNT_EN
    , .o_stall_cnt(scnt_a), .o_fwd_cnt(fcnt_a)
`endif
  );
  fwd_hazard_scoreboard #(.FWD_DEPTH(3), .LOAD_LAT(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_advance(adv), .i_ex_dst(ex_dst), .i_ex_wr_en(ex_wr),
    .i_ex_is_load(ex_ld), .i_ex_src(ex_src), .i_ex_src_used(ex_used), .i_id_src(id_src),
    .i_id_src_used(id_used), .o_fwd_sel(sel_b), .o_stall(stall_b)
`ifdef FWD_PERF_CNT_EN
    , .o_stall_cnt(scnt_b), .o_fwd_cnt(fcnt_b)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ex(input logic wr, input logic [4:0] dst, input logic ld,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    ex_wr = wr; ex_dst = dst; ex_ld = ld; ex_src = {s1, s0}; ex_used = used;
    #1;
  endtask
  task automatic set_id(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    id_src = {s1, s0}; id_used = used;
    #1;
  endtask
  task automatic do_reset();
    adv = 1'b1; rst = 1'b1;
    set_ex(0, 0, 0, 0, 0, 2'b00);
    set_id(0, 0, 2'b00);
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    set_ex(0, 5'd3, 0, 5'd3, 5'd5, 2'b11);
    set_id(5'd3, 5'd5, 2'b11);
    checks++;
    if (sel_a !== 4'd0) begin errors++; $display("FAIL reset_sel got=%h exp=0", sel_a); end
    checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b%b exp=00", stall_a, stall_b); end
  endtask
  task automatic test_fwd_mem();
    do_reset();
    set_ex(1, 5'd3, 0, 0, 0, 2'b00);
    tick();
    set_ex(0, 0, 0, 5'd3, 5'd8, 2'b11);
    checks++;
    if (sel_a !== 4'b0001) begin errors++; $display("FAIL fwd_mem got=%b exp=0001", sel_a); end
  endtask
  task automatic test_fwd_wb();
    do_reset();
    set_ex(1, 5'd7, 0, 0, 0, 2'b00);
    tick();
    set_ex(0, 0, 0, 0, 0, 2'b00);
    tick();
    set_ex(0, 0, 0, 0, 5'd7, 2'b10);
    checks++;
    if (sel_a !== 4'b1000) begin errors++; $display("FAIL fwd_wb got=%b exp=1000", sel_a); end
    set_ex(0, 0, 0, 0, 5'd7, 2'b00);
    checks++;
    if (sel_a !== 4'b0000) begin errors++; $display("FAIL fwd_unused got=%b exp=0000", sel_a); end
  endtask
  task automatic test_youngest();
    do_reset();
    set_ex(1, 5'd4, 0, 0, 0, 2'b00);
    tick();
    set_ex(1, 5'd4, 0, 0, 0, 2'b00);
    tick();
    set_ex(0, 0, 0, 5'd4, 0, 2'b01);
    checks++;
    if (sel_a !== 4'b0001) begin errors++; $display("FAIL youngest got=%b exp=0001", sel_a); end
    do_reset();
    set_ex(1, 5'd0, 0, 0, 0, 2'b00);
    tick();
    set_ex(0, 0, 0, 5'd0, 5'd0, 2'b11);
    checks++;
    if (sel_a !== 4'b0000) begin errors++; $display("FAIL r0_fwd got=%b exp=0000", sel_a); end
  endtask
  task automatic test_multi();
    do_reset();
    set_ex(1, 5'd10, 0, 0, 0, 2'b00);
    tick();
    set_ex(1, 5'd11, 0, 0, 0, 2'b00);
    tick();
    set_ex(0, 0, 0, 5'd10, 5'd11, 2'b11);
    checks++;
    if (sel_a !== 4'b0110) begin errors++; $display("FAIL multi got=%b exp=0110", sel_a); end
  endtask
  task automatic test_load_use();
    do_reset();
    set_ex(1, 5'd5, 1, 0, 0, 2'b00);
    set_id(5'd5, 0, 2'b01);
    checks++;
    if (stall_a !== 1'b1) begin errors++; $display("FAIL lu_stall0 got=%b exp=1", stall_a); end
    tick();
    set_ex(0, 0, 0, 5'd5, 0, 2'b01);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL lu_stall1 got=%b exp=0", stall_a); end
    checks++;
    if (sel_a !== 4'b0000) begin errors++; $display("FAIL lu_notready got=%b exp=0000", sel_a); end
    tick();
    set_id(0, 0, 2'b00);
    checks++;
    if (sel_a !== 4'b0010) begin errors++; $display("FAIL lu_fwd got=%b exp=0010", sel_a); end
    do_reset();
    set_ex(1, 5'd0, 1, 0, 0, 2'b00);
    set_id(5'd0, 0, 2'b01);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL lu_r0 got=%b exp=0", stall_a); end
    set_ex(1, 5'd5, 1, 0, 0, 2'b00);
    set_id(5'd5, 0, 2'b00);
    checks++;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL lu_unused got=%b exp=0", stall_a); end
  endtask
  task automatic test_load_use_lat2();
    do_reset();
    set_ex(1, 5'd5, 1, 0, 0, 2'b00);
    set_id(5'd5, 0, 2'b01);
    checks++;
    if (stall_b !== 1'b1) begin errors++; $display("FAIL lu2_stall0 got=%b exp=1", stall_b); end
    tick();
    set_ex(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (stall_b !== 1'b1) begin errors++; $display("FAIL lu2_stall1 got=%b exp=1", stall_b); end
    tick();
    checks++;
    if (stall_b !== 1'b0) begin errors++; $display("FAIL lu2_stall2 got=%b exp=0", stall_b); end
    tick();
    set_ex(0, 0, 0, 5'd5, 0, 2'b01);
    set_id(0, 0, 2'b00);
    checks++;
    if (sel_b !== 4'b0011) begin errors++; $display("FAIL lu2_fwd got=%b exp=0011", sel_b); end
    do_reset();
    set_ex(1, 5'd5, 1, 0, 0, 2'b00);
    tick();
    set_ex(1, 5'd5, 0, 0, 0, 2'b00);
    set_id(5'd5, 0, 2'b01);
    checks++;
    if (stall_b !== 1'b0) begin errors++; $display("FAIL lu2_younger got=%b exp=0", stall_b); end
  endtask
  task automatic test_freeze();
    do_reset();
    set_ex(1, 5'd9, 0, 0, 0, 2'b00);
    tick();
    adv = 1'b0;
    set_ex(1, 5'd12, 0, 0, 0, 2'b00);
    repeat (3) tick();
    set_ex(0, 0, 0, 5'd9, 5'd12, 2'b11);
    checks++;
    if (sel_a !== 4'b0001) begin errors++; $display("FAIL freeze_fwd got=%b exp=0001", sel_a); end
    set_ex(1, 5'd6, 1, 0, 0, 2'b00);
    set_id(5'd6, 0, 2'b01);
    repeat (2) tick();
    checks++;
    if (stall_a !== 1'b1) begin errors++; $display("FAIL freeze_stall got=%b exp=1", stall_a); end
    adv = 1'b1;
  endtask
  task automatic test_reset_mid();
    do_reset();
    set_ex(1, 5'd9, 0, 0, 0, 2'b00);
    tick();
    set_ex(1, 5'd5, 1, 0, 0, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ex(0, 0, 0, 5'd9, 5'd5, 2'b11);
    set_id(5'd5, 5'd9, 2'b11);
    checks++;
    if (sel_a !== 4'b0000 || sel_b !== 4'b0000) begin errors++; $display("FAIL rstmid_sel got=%b/%b exp=0000", sel_a, sel_b); end
    checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b%b exp=00", stall_a, stall_b); end
  endtask
`ifdef FWD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    repeat (3) begin
      set_ex(1, 5'd5, 1, 0, 0, 2'b00);
      set_id(5'd5, 0, 2'b01);
      tick();
      set_ex(0, 0, 0, 0, 0, 2'b00);
      tick();
      set_ex(0, 0, 0, 5'd5, 0, 2'b01);
      set_id(0, 0, 2'b00);
      tick();
    end
    set_ex(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (scnt_a !== 32'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", scnt_a); end
    checks++;
    if (fcnt_a !== 32'd3) begin errors++; $display("FAIL perf_fwd got=%0d exp=3", fcnt_a); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (scnt_a !== 32'd0 || fcnt_a !== 32'd0) begin errors++; $display("FAIL perf_clr got=%0d/%0d exp=0/0", scnt_a, fcnt_a); end
  endtask
`endif
  initial begin
    test_reset();
    test_fwd_mem();
    test_fwd_wb();
    test_youngest();
    test_multi();
    test_load_use();
    test_load_use_lat2();
    test_freeze();
    test_reset_mid();
`ifdef FWD_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
